// File: rtl/mult_32.sv
// mult_32: iterative 32x32 signed shift-and-add multiplier for the execute stage.
// Operand magnitudes are multiplied over 32 RUN cycles, then one FIX cycle
// restores the sign, checks for signed 32-bit overflow and pulses the ready flag.
module mult_32 (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        data_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mA_q, mA_d;
   logic [31:0] mB_q, mB_d;
   logic        neg_q, neg_d;
   logic [63:0] prod_q, prod_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        exception_q, exception_d;
   logic        resultRdy_q, resultRdy_d;

   logic [31:0] partial;
   logic [63:0] shifted;

   // Next-state logic: operand capture in IDLE, one partial product per RUN
   // cycle, and sign restoration plus overflow detection in FIX.
   always_comb begin
      state_d     = state_q;
      mA_d        = mA_q;
      mB_d        = mB_q;
      neg_d       = neg_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      exception_d = exception_q;
      resultRdy_d = 1'b0;

      partial = mA_q & {32{mB_q[cnt_q[4:0]]}};
      shifted = {32'd0, partial} << cnt_q;

      case (state_q)
         IDLE: begin
            if (ctrl_MULT) begin
               mA_d    = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
               mB_d    = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
               neg_d   = data_operandA[31] ^ data_operandB[31];
               prod_d  = 64'd0;
               cnt_d   = 6'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            prod_d = prod_q + shifted;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d    = neg_q ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
            exception_d = neg_q ? (prod_q > 64'h0000_0000_8000_0000)
                                : (prod_q > 64'h0000_0000_7FFF_FFFF);
            resultRdy_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset; reset aborts any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         mA_q        <= 32'd0;
         mB_q        <= 32'd0;
         neg_q       <= 1'b0;
         prod_q      <= 64'd0;
         cnt_q       <= 6'd0;
         result_q    <= 32'd0;
         exception_q <= 1'b0;
         resultRdy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mA_q        <= mA_d;
         mB_q        <= mB_d;
         neg_q       <= neg_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         exception_q <= exception_d;
         resultRdy_q <= resultRdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exception_q;
   assign data_resultRDY = resultRdy_q;
   assign data_busy      = (state_q == RUN) || (state_q == FIX);

endmodule
